// File: rtl/clause_len8_pkg.sv
// Shared SAT literal encoding: slot width and the four 2-bit literal codes.
package clause_len8_pkg;

  localparam int SLOT_W = 2;

  localparam logic [SLOT_W-1:0] LIT_NONE = 2'b00;
  localparam logic [SLOT_W-1:0] LIT_POS  = 2'b10;
  localparam logic [SLOT_W-1:0] LIT_NEG  = 2'b01;
  localparam logic [SLOT_W-1:0] LIT_ILL  = 2'b11;

  // Any set bit marks the slot occupied, the illegal code included.
  function automatic logic slot_occupied(input logic [SLOT_W-1:0] slot);
    return |slot;
  endfunction

endpackage

// File: rtl/clause_len8_lit_popcount.sv
// Combinational population count of the occupied-slot mask.
module lit_popcount #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] count
);

  // Sum one bit per slot.
  always_comb begin
    count = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      count = count + W'(mask[i]);
    end
  end

endmodule

// File: rtl/clause_len8.sv
// Clause analyser: decodes packed literal slots and registers length, masks,
// first occupied index and illegal flag with one cycle of latency.
module clause_len8 #(
  parameter int NUM_VARS = 8,
  parameter int WIDTH    = 4,
  localparam int IDX_W   = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [NUM_VARS*2-1:0] clause_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      len_o,
  output logic [NUM_VARS-1:0]   pos_mask_o,
  output logic [NUM_VARS-1:0]   neg_mask_o,
  output logic                  empty_o,
  output logic                  unit_o,
  output logic [IDX_W-1:0]      first_idx_o,
  output logic                  illegal_o
);

  import clause_len8_pkg::*;

  logic [NUM_VARS-1:0] occ_mask;
  logic [NUM_VARS-1:0] pos_mask;
  logic [NUM_VARS-1:0] neg_mask;
  logic [NUM_VARS-1:0] ill_mask;
  logic [WIDTH-1:0]    count;
  logic [IDX_W-1:0]    first_idx;

  // Single-level slot decode; illegal slots are occupied but in neither mask.
  always_comb begin
    logic [SLOT_W-1:0] slot;
    slot     = LIT_NONE;
    occ_mask = {NUM_VARS{1'b0}};
    pos_mask = {NUM_VARS{1'b0}};
    neg_mask = {NUM_VARS{1'b0}};
    ill_mask = {NUM_VARS{1'b0}};
    for (int i = 0; i < NUM_VARS; i++) begin
      slot        = clause_i[SLOT_W*i +: SLOT_W];
      occ_mask[i] = slot_occupied(slot);
      case (slot)
        LIT_POS: pos_mask[i] = 1'b1;
        LIT_NEG: neg_mask[i] = 1'b1;
        LIT_ILL: ill_mask[i] = 1'b1;
        default: occ_mask[i] = 1'b0;
      endcase
    end
  end

  lit_popcount #(
    .N (NUM_VARS),
    .W (WIDTH)
  ) u_popcount (
    .mask  (occ_mask),
    .count (count)
  );

  // Priority encoder: scanning downward lets the lowest occupied index win.
  always_comb begin
    first_idx = {IDX_W{1'b0}};
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (occ_mask[i]) begin
        first_idx = IDX_W'(i);
      end else begin
        first_idx = first_idx;
      end
    end
  end

  // Output registers; data holds whenever no new clause is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o     <= 1'b0;
      len_o       <= {WIDTH{1'b0}};
      pos_mask_o  <= {NUM_VARS{1'b0}};
      neg_mask_o  <= {NUM_VARS{1'b0}};
      empty_o     <= 1'b1;
      unit_o      <= 1'b0;
      first_idx_o <= {IDX_W{1'b0}};
      illegal_o   <= 1'b0;
    end else if (valid_i) begin
      valid_o     <= 1'b1;
      len_o       <= count;
      pos_mask_o  <= pos_mask;
      neg_mask_o  <= neg_mask;
      empty_o     <= (count == {WIDTH{1'b0}});
      unit_o      <= (count == WIDTH'(1));
      first_idx_o <= first_idx;
      illegal_o   <= |ill_mask;
    end else begin
      valid_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clause_len8.sv
// Self-checking bench for clause_len8: directed vector table, hand sequences
// and randomized traffic against an arithmetic reference model.
module tb_clause_len8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [15:0] clause_i;
  logic        valid_o;
  logic [3:0]  len_o;
  logic [7:0]  pos_mask_o;
  logic [7:0]  neg_mask_o;
  logic        empty_o;
  logic        unit_o;
  logic [2:0]  first_idx_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show now.
  logic       m_valid;
  int         m_len;
  int         m_pos;
  int         m_neg;
  int         m_first;
  logic       m_ill;
  logic       m_empty;
  logic       m_unit;

  typedef struct {
    logic [15:0] clause;
    int          len;
    int          pos;
    int          neg;
    int          first;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  clause_len8 dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .clause_i    (clause_i),
    .valid_o     (valid_o),
    .len_o       (len_o),
    .pos_mask_o  (pos_mask_o),
    .neg_mask_o  (neg_mask_o),
    .empty_o     (empty_o),
    .unit_o      (unit_o),
    .first_idx_o (first_idx_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot-by-slot arithmetic evaluation of a clause.
  task automatic ref_eval(input logic [15:0] c);
    int s;
    m_len = 0; m_pos = 0; m_neg = 0; m_first = -1; m_ill = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = (int'(c) >> (2 * i)) & 3;
      if (s != 0) begin
        m_len++;
        if (m_first < 0) m_first = i;
      end
      if (s == 2) m_pos += (1 << i);
      if (s == 1) m_neg += (1 << i);
      if (s == 3) m_ill = 1'b1;
    end
    if (m_first < 0) m_first = 0;
    m_empty = (m_len == 0);
    m_unit  = (m_len == 1);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, int'(valid_o), int'(m_valid));
    chk({tag, ".len"},   int'(len_o), m_len);
    chk({tag, ".pos"},   int'(pos_mask_o), m_pos);
    chk({tag, ".neg"},   int'(neg_mask_o), m_neg);
    chk({tag, ".empty"}, int'(empty_o), int'(m_empty));
    chk({tag, ".unit"},  int'(unit_o), int'(m_unit));
    chk({tag, ".first"}, int'(first_idx_o), m_first);
    chk({tag, ".ill"},   int'(illegal_o), int'(m_ill));
  endtask

  // Drive one cycle, advance the model by the same edge, then compare.
  task automatic step(input logic v, input logic [15:0] c, input logic r, input string tag);
    @(negedge clk);
    valid_i = v; clause_i = c; rst = r;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_len = 0; m_pos = 0; m_neg = 0; m_first = 0;
      m_ill = 1'b0; m_empty = 1'b1; m_unit = 1'b0;
    end else if (v) begin
      ref_eval(c);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; clause_i = 16'h0000;

    vecs[0] = '{16'h0000, 0, 8'h00, 8'h00, 0, 1'b0};
    vecs[1] = '{16'b00_00_00_00_00_10_00_00, 1, 8'h04, 8'h00, 2, 1'b0};
    vecs[2] = '{16'b01_10_01_10_01_10_01_10, 8, 8'h55, 8'hAA, 0, 1'b0};
    vecs[3] = '{16'b00_11_00_00_00_00_00_01, 2, 8'h00, 8'h01, 0, 1'b1};
    vecs[4] = '{16'hFFFF, 8, 8'h00, 8'h00, 0, 1'b1};
    vecs[5] = '{16'h8000, 1, 8'h80, 8'h00, 7, 1'b0};
    vecs[6] = '{16'h4000, 1, 8'h00, 8'h80, 7, 1'b0};
    vecs[7] = '{16'h0300, 1, 8'h00, 8'h00, 4, 1'b1};

    // Two reset cycles, then explicit reset values.
    step(1'b1, 16'hFFFF, 1'b1, "rst0");
    step(1'b1, 16'hFFFF, 1'b1, "rst1");
    chk("reset.valid", int'(valid_o), 0);
    chk("reset.empty", int'(empty_o), 1);
    chk("reset.len",   int'(len_o), 0);

    // Directed table against hand-computed constants.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, vecs[k].clause, 1'b0, $sformatf("vec%0d", k));
      chk($sformatf("tbl%0d.len", k),   int'(len_o), vecs[k].len);
      chk($sformatf("tbl%0d.pos", k),   int'(pos_mask_o), vecs[k].pos);
      chk($sformatf("tbl%0d.neg", k),   int'(neg_mask_o), vecs[k].neg);
      chk($sformatf("tbl%0d.first", k), int'(first_idx_o), vecs[k].first);
      chk($sformatf("tbl%0d.ill", k),   int'(illegal_o), int'(vecs[k].ill));
      chk($sformatf("tbl%0d.empty", k), int'(empty_o), int'(vecs[k].len == 0));
      chk($sformatf("tbl%0d.unit", k),  int'(unit_o), int'(vecs[k].len == 1));
      chk($sformatf("tbl%0d.valid", k), int'(valid_o), 1);
    end

    // Back-to-back, idle with changing input (data must hold), reset mid-stream.
    step(1'b1, 16'b00_00_00_00_00_10_00_00, 1'b0, "seq_a");
    step(1'b1, 16'b01_10_01_10_01_10_01_10, 1'b0, "seq_b");
    step(1'b1, 16'b00_11_00_00_00_00_00_01, 1'b0, "seq_c");
    step(1'b0, 16'hAAAA, 1'b0, "seq_idle");
    chk("hold.len", int'(len_o), 2);
    chk("hold.ill", int'(illegal_o), 1);
    step(1'b1, 16'h0002, 1'b0, "seq_d");
    step(1'b1, 16'h5555, 1'b1, "seq_rst");
    chk("midrst.empty", int'(empty_o), 1);
    step(1'b1, 16'h0010, 1'b0, "seq_after");
    chk("after.first", int'(first_idx_o), 2);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] c;
      logic        v;
      logic        r;
      c = 16'($urandom);
      if ($urandom_range(0, 3) == 0) c = c & 16'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 39) == 0);
      step(v, c, r, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
